// File: rtl/game_flow_pkg.sv
// Shared encodings for the game flow sequencer: FSM state codes and the
// coarse phase code consumed by the VGA arbiter.
package game_flow_pkg;

    localparam logic [3:0] S_RESET       = 4'd0;
    localparam logic [3:0] S_WAIT_START  = 4'd1;
    localparam logic [3:0] S_BEGIN       = 4'd2;
    localparam logic [3:0] S_DRAW_TOWER  = 4'd3;
    localparam logic [3:0] S_IN_PROGRESS = 4'd4;
    localparam logic [3:0] S_PAUSED      = 4'd5;
    localparam logic [3:0] S_LIFE_LOST   = 4'd6;
    localparam logic [3:0] S_STAGE_DONE  = 4'd7;
    localparam logic [3:0] S_WIN         = 4'd8;
    localparam logic [3:0] S_GAME_OVER   = 4'd9;

    typedef enum logic [2:0] {
        PH_WAIT  = 3'd0,
        PH_BEGIN = 3'd1,
        PH_TOWER = 3'd2,
        PH_PLAY  = 3'd3,
        PH_DONE  = 3'd4,
        PH_END   = 3'd5
    } phase_t;

    // Paused and life-lost frames keep the arbiter on the play/begin layers.
    function automatic phase_t state_to_phase(input logic [3:0] s);
        case (s)
            S_BEGIN, S_LIFE_LOST:     return PH_BEGIN;
            S_DRAW_TOWER:             return PH_TOWER;
            S_IN_PROGRESS, S_PAUSED:  return PH_PLAY;
            S_STAGE_DONE:             return PH_DONE;
            S_WIN, S_GAME_OVER:       return PH_END;
            default:                  return PH_WAIT;
        endcase
    endfunction

endpackage

// File: rtl/game_flow_counters.sv
// Stage index and lives counters, driven by one-cycle strobes from the FSM.
module game_flow_counters #(
    parameter int NUM_STAGES = 3,
    parameter int NUM_LIVES  = 3,
    parameter int SW         = 2,
    parameter int LW         = 2
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          load,
    input  logic          stage_inc,
    input  logic          lives_dec,
    output logic [SW-1:0] stage_idx,
    output logic [LW-1:0] lives_left
);

    // Saturating guards keep the index in range even if a stray strobe arrives.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stage_idx  <= '0;
            lives_left <= LW'(NUM_LIVES);
        end else if (load) begin
            stage_idx  <= '0;
            lives_left <= LW'(NUM_LIVES);
        end else begin
            if (stage_inc && (stage_idx != SW'(NUM_STAGES - 1)))
                stage_idx <= stage_idx + SW'(1);
            if (lives_dec && (lives_left != '0))
                lives_left <= lives_left - LW'(1);
        end
    end

endmodule

// File: rtl/game_flow_sequencer.sv
// Top-level game flow FSM: stage/phase sequencing, lives and retry, pause,
// and registered Moore decodes for the drawers, datapaths and VGA arbiter.
module game_flow_sequencer #(
    parameter  int NUM_STAGES = 3,
    parameter  int NUM_LIVES  = 3,
    localparam int SW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1,
    localparam int LW = $clog2(NUM_LIVES + 1)
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  start_display_done,
    input  logic                  begin_done,
    input  logic                  tower_done,
    input  logic                  car_done,
    input  logic                  end_display_done,
    input  logic                  game_over_in,
    input  logic                  pause,
    input  logic                  restart,
    output logic [SW-1:0]         stage_idx,
    output logic [NUM_STAGES-1:0] stage_onehot,
    output logic                  wait_start,
    output logic                  stage_begin,
    output logic                  stage_draw_tower,
    output logic                  stage_in_progress,
    output logic                  stage_done,
    output logic                  paused,
    output logic                  win,
    output logic                  game_over_out,
    output logic [LW-1:0]         lives_left,
    output logic                  life_lost,
    output logic                  phase_start
);
    import game_flow_pkg::*;

    logic [3:0] state, next_state, prev_state;
    logic       load, stage_inc, lives_dec;
    logic       last_stage, in_stage_phase, entry_d;
    logic [NUM_STAGES-1:0] onehot_d;

    game_flow_counters #(
        .NUM_STAGES (NUM_STAGES),
        .NUM_LIVES  (NUM_LIVES),
        .SW         (SW),
        .LW         (LW)
    ) u_counters (
        .clk        (clk),
        .resetn     (resetn),
        .load       (load),
        .stage_inc  (stage_inc),
        .lives_dec  (lives_dec),
        .stage_idx  (stage_idx),
        .lives_left (lives_left)
    );

    assign last_stage = (stage_idx == SW'(NUM_STAGES - 1));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= S_RESET;
        else         state <= next_state;
    end

    // The final life takes the decrement to zero on the way into GAME_OVER.
    always_comb begin
        next_state = state;
        load       = 1'b0;
        stage_inc  = 1'b0;
        lives_dec  = 1'b0;
        case (state)
            S_RESET:      next_state = S_WAIT_START;
            S_WAIT_START: if (start_display_done) begin
                              next_state = S_BEGIN;
                              load       = 1'b1;
                          end
            S_BEGIN:      if (begin_done) next_state = S_DRAW_TOWER;
            S_DRAW_TOWER: if (tower_done) next_state = S_IN_PROGRESS;
            S_IN_PROGRESS: begin
                if (car_done) begin
                    next_state = S_STAGE_DONE;
                end else if (game_over_in) begin
                    lives_dec  = 1'b1;
                    next_state = (lives_left > LW'(1)) ? S_LIFE_LOST : S_GAME_OVER;
                end else if (pause) begin
                    next_state = S_PAUSED;
                end
            end
            S_PAUSED:     if (!pause) next_state = S_IN_PROGRESS;
            S_LIFE_LOST:  next_state = S_BEGIN;
            S_STAGE_DONE: if (end_display_done) begin
                              if (last_stage) begin
                                  next_state = S_WIN;
                              end else begin
                                  stage_inc  = 1'b1;
                                  next_state = S_BEGIN;
                              end
                          end
            S_WIN, S_GAME_OVER: if (restart) begin
                              next_state = S_WAIT_START;
                              load       = 1'b1;
                          end
            default:      next_state = S_WAIT_START;
        endcase
    end

    // Resuming from PAUSED is not a new phase, so it does not raise phase_start.
    always_comb begin
        in_stage_phase = (state >= S_BEGIN) && (state <= S_STAGE_DONE);
        entry_d = (state != prev_state) &&
                  ((state == S_BEGIN) || (state == S_DRAW_TOWER) ||
                   (state == S_STAGE_DONE) ||
                   ((state == S_IN_PROGRESS) && (prev_state != S_PAUSED)));
        onehot_d = '0;
        for (int i = 0; i < NUM_STAGES; i++)
            onehot_d[i] = in_stage_phase && (stage_idx == SW'(i));
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            prev_state        <= S_RESET;
            wait_start        <= 1'b0;
            stage_begin       <= 1'b0;
            stage_draw_tower  <= 1'b0;
            stage_in_progress <= 1'b0;
            stage_done        <= 1'b0;
            paused            <= 1'b0;
            win               <= 1'b0;
            game_over_out     <= 1'b0;
            life_lost         <= 1'b0;
            phase_start       <= 1'b0;
            stage_onehot      <= '0;
        end else begin
            prev_state        <= state;
            wait_start        <= (state == S_WAIT_START);
            stage_begin       <= (state == S_BEGIN);
            stage_draw_tower  <= (state == S_DRAW_TOWER);
            stage_in_progress <= (state == S_IN_PROGRESS);
            stage_done        <= (state == S_STAGE_DONE);
            paused            <= (state == S_PAUSED);
            win               <= (state == S_WIN);
            game_over_out     <= (state == S_GAME_OVER);
            life_lost         <= (state == S_LIFE_LOST);
            phase_start       <= entry_d;
            stage_onehot      <= onehot_d;
        end
    end

endmodule
